// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: condition-code encodings,
// carry-source select encodings, FSM state encoding and the flags bundle
// consumed by the condition evaluator.
package branch_resolver_pkg;

    typedef enum logic [3:0] {
        COND_ALWAYS = 4'd0,
        COND_Z      = 4'd1,
        COND_NZ     = 4'd2,
        COND_C      = 4'd3,
        COND_NC     = 4'd4,
        COND_S      = 4'd5,
        COND_NS     = 4'd6,
        COND_V      = 4'd7,
        COND_NV     = 4'd8,
        COND_HI     = 4'd9,
        COND_LS     = 4'd10,
        COND_GE     = 4'd11,
        COND_LT     = 4'd12,
        COND_GT     = 4'd13,
        COND_LE     = 4'd14,
        COND_NEVER  = 4'd15
    } cond_t;

    typedef enum logic [1:0] {
        CSEL_ARITH = 2'd0,
        CSEL_LOGIC = 2'd1,
        CSEL_ZERO  = 2'd2,
        CSEL_ONE   = 2'd3
    } csel_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FLAGS = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

    // Flush counter only has to hold FLUSH_DEPTH (1..3).
    localparam int FLUSH_CNT_W = 2;

    typedef struct packed {
        logic arith_carry;
        logic logic_carry;
        logic zero;
        logic sign;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Branch resolver bus: branch request from execute, ALU flags from the flags
// register, and the redirect/flush/statistics outputs toward fetch.
//   master : execute/fetch side (drives request + flags, observes results)
//   slave  : branch_resolver
interface branch_resolver_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              branchValid;
    logic [3:0]        condCode;
    logic [ADDR_W-1:0] targetIn;
    logic              flagsPending;
    logic              arithCarry;
    logic              logicCarry;
    logic              zero;
    logic              sign;
    logic              overflow;
    logic [1:0]        CarrySelectDelayed;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] pcTarget;
    logic              flush;
    logic [CNT_W-1:0]  takenCount;

    modport master (
        output branchValid, condCode, targetIn, flagsPending,
               arithCarry, logicCarry, zero, sign, overflow, CarrySelectDelayed,
        input  stall, redirect, pcTarget, flush, takenCount
    );

    modport slave (
        input  branchValid, condCode, targetIn, flagsPending,
               arithCarry, logicCarry, zero, sign, overflow, CarrySelectDelayed,
        output stall, redirect, pcTarget, flush, takenCount
    );
endinterface

// File: rtl/branch_resolver_cond_eval.sv
// cond_eval: purely combinational branch condition evaluation.
//   flags  : current ALU flags
//   csel   : carry source select for the effective carry C
//   cond   : 4-bit condition code
//   taken  : condition holds (never for COND_NEVER)
module cond_eval
    import branch_resolver_pkg::*;
(
    input  flags_t     flags,
    input  logic [1:0] csel,
    input  logic [3:0] cond,
    output logic       taken
);
    logic c;
    logic ge;

    always_comb begin
        case (csel_t'(csel))
            CSEL_ARITH: c = flags.arith_carry;
            CSEL_LOGIC: c = flags.logic_carry;
            CSEL_ZERO:  c = 1'b0;
            default:    c = 1'b1;
        endcase
    end

    assign ge = (flags.sign == flags.overflow);

    always_comb begin
        case (cond_t'(cond))
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = flags.zero;
            COND_NZ:     taken = ~flags.zero;
            COND_C:      taken = c;
            COND_NC:     taken = ~c;
            COND_S:      taken = flags.sign;
            COND_NS:     taken = ~flags.sign;
            COND_V:      taken = flags.overflow;
            COND_NV:     taken = ~flags.overflow;
            COND_HI:     taken = c & ~flags.zero;
            COND_LS:     taken = ~c | flags.zero;
            COND_GE:     taken = ge;
            COND_LT:     taken = ~ge;
            COND_GT:     taken = ~flags.zero & ge;
            COND_LE:     taken = flags.zero | ~ge;
            default:     taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves branches against the registered ALU flags.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of branch_resolver_if
//     stall      - combinational hold while a flag update is in flight
//     redirect   - one-cycle PC load pulse, pcTarget valid with it
//     flush      - squash pulse for FLUSH_DEPTH cycles after a taken branch
//     takenCount - saturating taken-branch counter
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    branch_resolver_if.slave bus
);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_DEPTH);

    state_t                 state_q, state_d;
    logic [3:0]             cond_q, cond_d;
    logic [ADDR_W-1:0]      target_q, target_d;
    logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   redirect_q, redirect_d;
    logic [ADDR_W-1:0]      pc_target_q, pc_target_d;
    logic                   flush_q, flush_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic              idle;
    logic              do_eval;
    logic              taken;
    logic [3:0]        eval_cond;
    logic [ADDR_W-1:0] eval_tgt;
    flags_t            flags;

    assign idle = (state_q == ST_IDLE);

    // WAIT_FLAGS re-evaluates the latched branch; the live request is
    // ignored that cycle.
    assign eval_cond = idle ? bus.condCode : cond_q;
    assign eval_tgt  = idle ? bus.targetIn : target_q;
    assign do_eval   = (idle && bus.branchValid && !bus.flagsPending)
                     || (state_q == ST_WAIT_FLAGS);

    assign flags = '{arith_carry: bus.arithCarry, logic_carry: bus.logicCarry,
                     zero: bus.zero, sign: bus.sign, overflow: bus.overflow};

    cond_eval u_cond_eval (
        .flags (flags),
        .csel  (bus.CarrySelectDelayed),
        .cond  (eval_cond),
        .taken (taken)
    );

    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        target_d    = target_q;
        fcnt_d      = fcnt_q;
        redirect_d  = 1'b0;
        pc_target_d = pc_target_q;
        flush_d     = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.branchValid && bus.flagsPending) begin
                    cond_d   = bus.condCode;
                    target_d = bus.targetIn;
                    state_d  = ST_WAIT_FLAGS;
                end
            end
            ST_WAIT_FLAGS: state_d = ST_IDLE;
            ST_FLUSH: begin
                // flush_q is already high for this cycle; keep it up until
                // the counter reaches 1.
                if (fcnt_q <= FLUSH_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d  = fcnt_q - 1'b1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_eval && taken) begin
            redirect_d  = 1'b1;
            pc_target_d = eval_tgt;
            flush_d     = 1'b1;
            fcnt_d      = FLUSH_INIT;
            state_d     = ST_FLUSH;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cond_q      <= '0;
            target_q    <= '0;
            fcnt_q      <= '0;
            redirect_q  <= 1'b0;
            pc_target_q <= '0;
            flush_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cond_q      <= cond_d;
            target_q    <= target_d;
            fcnt_q      <= fcnt_d;
            redirect_q  <= redirect_d;
            pc_target_q <= pc_target_d;
            flush_q     <= flush_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.stall      = idle && bus.branchValid && bus.flagsPending;
    assign bus.redirect   = redirect_q;
    assign bus.pcTarget   = pc_target_q;
    assign bus.flush      = flush_q;
    assign bus.takenCount = cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolver_if #(.ADDR_W(8), .CNT_W(16)) bus ();
    branch_resolver_if #(.ADDR_W(8), .CNT_W(3))  bus_s ();

    branch_resolver #(.ADDR_W(8), .FLUSH_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));

    // Small-counter, single-flush instance for saturation.
    branch_resolver #(.ADDR_W(8), .FLUSH_DEPTH(1), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

    task automatic set_br(input logic bv, input logic fp, input logic [3:0] cc, input logic [7:0] tgt);
        bus.branchValid  = bv;
        bus.flagsPending = fp;
        bus.condCode     = cc;
        bus.targetIn     = tgt;
    endtask

    task automatic set_flags(input logic ac, input logic lc, input logic z, input logic s,
                             input logic v, input logic [1:0] csel);
        bus.arithCarry = ac; bus.logicCarry = lc; bus.zero = z;
        bus.sign = s; bus.overflow = v; bus.CarrySelectDelayed = csel;
    endtask

    task automatic test_reset();
        set_br(0, 0, 4'd0, 8'h00);
        set_flags(0, 0, 0, 0, 0, 2'd0);
        bus_s.branchValid = 0; bus_s.flagsPending = 0; bus_s.condCode = 4'd0;
        bus_s.targetIn = 8'h00; bus_s.arithCarry = 0; bus_s.logicCarry = 0;
        bus_s.zero = 0; bus_s.sign = 0; bus_s.overflow = 0; bus_s.CarrySelectDelayed = 2'd0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%0b exp=0", bus.redirect); end
        checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", bus.flush); end
        checks++; if (bus.pcTarget !== 8'h00) begin failures++; $display("FAIL reset_pctarget got=%h exp=00", bus.pcTarget); end
        checks++; if (bus.takenCount !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.takenCount); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_taken_z();
        set_flags(0, 0, 1, 0, 0, 2'd0);
        set_br(1, 0, 4'd1, 8'h3C);
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL tz_stall got=%0b exp=0", bus.stall); end
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b1) begin failures++; $display("FAIL tz_redirect got=%0b exp=1", bus.redirect); end
        checks++; if (bus.pcTarget !== 8'h3C) begin failures++; $display("FAIL tz_pctarget got=%h exp=3c", bus.pcTarget); end
        checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL tz_flush1 got=%0b exp=1", bus.flush); end
        set_br(0, 0, 4'd0, 8'h00);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL tz_redirect_drop got=%0b exp=0", bus.redirect); end
        checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL tz_flush2 got=%0b exp=1", bus.flush); end
        @(negedge clk);
        checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL tz_flush_end got=%0b exp=0", bus.flush); end
        checks++; if (bus.takenCount !== 16'd1) begin failures++; $display("FAIL tz_count got=%0d exp=1", bus.takenCount); end
    endtask

    task automatic test_gt();
        set_flags(0, 0, 0, 1, 0, 2'd0);
        set_br(1, 0, 4'd13, 8'h50);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL gt_nt_redirect got=%0b exp=0", bus.redirect); end
        checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL gt_nt_flush got=%0b exp=0", bus.flush); end
        checks++; if (bus.takenCount !== 16'd1) begin failures++; $display("FAIL gt_nt_count got=%0d exp=1", bus.takenCount); end
        set_flags(0, 0, 0, 1, 1, 2'd0);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b1) begin failures++; $display("FAIL gt_t_redirect got=%0b exp=1", bus.redirect); end
        checks++; if (bus.pcTarget !== 8'h50) begin failures++; $display("FAIL gt_t_pctarget got=%h exp=50", bus.pcTarget); end
        set_br(0, 0, 4'd0, 8'h00);
        repeat (2) @(negedge clk);
        checks++; if (bus.takenCount !== 16'd2) begin failures++; $display("FAIL gt_t_count got=%0d exp=2", bus.takenCount); end
    endtask

    task automatic test_carry_sel();
        // logic carry selected: C=1 -> taken
        set_flags(0, 1, 0, 0, 0, 2'd1);
        set_br(1, 0, 4'd3, 8'h61);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b1) begin failures++; $display("FAIL csel1_redirect got=%0b exp=1", bus.redirect); end
        set_br(0, 0, 4'd0, 8'h00);
        repeat (2) @(negedge clk);
        // constant 0 carry -> not taken
        set_flags(0, 1, 0, 0, 0, 2'd2);
        set_br(1, 0, 4'd3, 8'h62);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL csel2_redirect got=%0b exp=0", bus.redirect); end
        // arith carry 0 -> not taken
        set_flags(0, 1, 0, 0, 0, 2'd0);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL csel0_redirect got=%0b exp=0", bus.redirect); end
        // COND_NEVER with everything set -> not taken
        set_flags(1, 1, 1, 1, 1, 2'd3);
        set_br(1, 0, 4'd15, 8'h63);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL never_redirect got=%0b exp=0", bus.redirect); end
        // constant 1 carry, HI with Z=0 -> taken
        set_flags(0, 0, 0, 0, 0, 2'd3);
        set_br(1, 0, 4'd9, 8'h64);
        @(negedge clk);
        checks++; if (bus.pcTarget !== 8'h64 || bus.redirect !== 1'b1) begin failures++; $display("FAIL csel3_hi got=%0b/%h exp=1/64", bus.redirect, bus.pcTarget); end
        set_br(0, 0, 4'd0, 8'h00);
        repeat (2) @(negedge clk);
        checks++; if (bus.takenCount !== 16'd4) begin failures++; $display("FAIL csel_count got=%0d exp=4", bus.takenCount); end
    endtask

    task automatic test_hazard();
        set_flags(0, 0, 0, 0, 0, 2'd0);
        set_br(1, 1, 4'd1, 8'h80);
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL hz_stall got=%0b exp=1", bus.stall); end
        @(negedge clk);
        // WAIT_FLAGS: flags now updated; a new request here must be ignored
        set_flags(0, 0, 1, 0, 0, 2'd0);
        set_br(1, 1, 4'd0, 8'h99);
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL hz_wait_stall got=%0b exp=0", bus.stall); end
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL hz_early_redirect got=%0b exp=0", bus.redirect); end
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b1 || bus.pcTarget !== 8'h80) begin failures++; $display("FAIL hz_redirect got=%0b/%h exp=1/80", bus.redirect, bus.pcTarget); end
        set_br(0, 0, 4'd0, 8'h00);
        repeat (2) @(negedge clk);
        checks++; if (bus.redirect !== 1'b0 || bus.takenCount !== 16'd5) begin failures++; $display("FAIL hz_count got=%0b/%0d exp=0/5", bus.redirect, bus.takenCount); end
    endtask

    task automatic test_flush_ignore();
        set_flags(0, 0, 0, 0, 0, 2'd0);
        set_br(1, 0, 4'd0, 8'h11);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b1 || bus.pcTarget !== 8'h11) begin failures++; $display("FAIL fi_redirect got=%0b/%h exp=1/11", bus.redirect, bus.pcTarget); end
        set_br(1, 0, 4'd0, 8'h22);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b1) begin failures++; $display("FAIL fi_f1 got=%0b/%0b exp=0/1", bus.redirect, bus.flush); end
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0 || bus.flush !== 1'b0 || bus.pcTarget !== 8'h11) begin failures++; $display("FAIL fi_f2 got=%0b/%0b/%h exp=0/0/11", bus.redirect, bus.flush, bus.pcTarget); end
        checks++; if (bus.takenCount !== 16'd6) begin failures++; $display("FAIL fi_count got=%0d exp=6", bus.takenCount); end
        // first cycle back in IDLE: accepted
        set_br(1, 0, 4'd0, 8'h33);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b1 || bus.pcTarget !== 8'h33) begin failures++; $display("FAIL fi_after got=%0b/%h exp=1/33", bus.redirect, bus.pcTarget); end
        set_br(0, 0, 4'd0, 8'h00);
        repeat (2) @(negedge clk);
        checks++; if (bus.takenCount !== 16'd7) begin failures++; $display("FAIL fi_count2 got=%0d exp=7", bus.takenCount); end
    endtask

    task automatic test_back_to_back();
        set_flags(0, 0, 1, 0, 0, 2'd0);
        set_br(1, 0, 4'd15, 8'h40);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL b2b_nt1 got=%0b exp=0", bus.redirect); end
        set_br(1, 0, 4'd2, 8'h41);   // ~Z with Z=1
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL b2b_nt2 got=%0b exp=0", bus.redirect); end
        set_br(1, 0, 4'd1, 8'h42);   // Z -> taken, no bubble
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b1 || bus.pcTarget !== 8'h42) begin failures++; $display("FAIL b2b_t got=%0b/%h exp=1/42", bus.redirect, bus.pcTarget); end
        set_br(0, 0, 4'd0, 8'h00);
        repeat (2) @(negedge clk);
        checks++; if (bus.takenCount !== 16'd8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", bus.takenCount); end
    endtask

    task automatic test_reset_mid();
        set_flags(0, 0, 0, 0, 0, 2'd0);
        set_br(1, 0, 4'd0, 8'h55);
        @(negedge clk);
        set_br(0, 0, 4'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.redirect !== 1'b0) begin failures++; $display("FAIL rm_flush got=%0b/%0b exp=0/0", bus.flush, bus.redirect); end
        checks++; if (bus.takenCount !== 16'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", bus.takenCount); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.flush !== 1'b0 || bus.redirect !== 1'b0) begin failures++; $display("FAIL rm_after got=%0b/%0b exp=0/0", bus.flush, bus.redirect); end
        // reset during WAIT_FLAGS abandons the branch
        set_br(1, 1, 4'd0, 8'h77);
        @(negedge clk);
        set_br(0, 0, 4'd0, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if (bus.redirect !== 1'b0 || bus.pcTarget !== 8'h00) begin failures++; $display("FAIL rw_after got=%0b/%h exp=0/00", bus.redirect, bus.pcTarget); end
        end
        // idle-state acceptance after reset
        set_br(1, 0, 4'd0, 8'h78);
        @(negedge clk);
        checks++; if (bus.redirect !== 1'b1 || bus.takenCount !== 16'd1) begin failures++; $display("FAIL rw_accept got=%0b/%0d exp=1/1", bus.redirect, bus.takenCount); end
        set_br(0, 0, 4'd0, 8'h00);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 9; i++) begin
            bus_s.branchValid = 1'b1;
            @(negedge clk);
            bus_s.branchValid = 1'b0;
            checks++; if (bus_s.redirect !== 1'b1 || bus_s.flush !== 1'b1) begin failures++; $display("FAIL sat_pulse%0d got=%0b/%0b exp=1/1", i, bus_s.redirect, bus_s.flush); end
            @(negedge clk);
            if (i == 5) begin
                checks++; if (bus_s.takenCount !== 3'd5) begin failures++; $display("FAIL sat_mid got=%0d exp=5", bus_s.takenCount); end
            end
        end
        checks++; if (bus_s.flush !== 1'b0) begin failures++; $display("FAIL sat_flush1 got=%0b exp=0", bus_s.flush); end
        checks++; if (bus_s.takenCount !== 3'd7) begin failures++; $display("FAIL sat_count got=%0d exp=7", bus_s.takenCount); end
    endtask

    initial begin
        test_reset();
        test_taken_z();
        test_gt();
        test_carry_sel();
        test_hazard();
        test_flush_ignore();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Consumer of the registered ALU status flags (arithmetic/logic carry, zero, sign, overflow, delayed carry select) in the pipelined CPU. Evaluates the 4-bit condition code of a branch instruction against those flags, stalls the issuing stage while a flag update is still in flight, redirects the PC on a taken branch and squashes the two wrong-path instructions behind it. Sits between decode/execute and fetch, directly downstream of the flags register.

## Interface
Parameters:
- `ADDR_W`, 8, PC/target width.
- `FLUSH_DEPTH`, 2, wrong-path instructions squashed after a taken branch (1..3).
- `CNT_W`, 16, width of the taken-branch statistics counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `branchValid`  in  1  branch instruction present in execute this cycle.
- `condCode`  in  4  branch condition.
- `targetIn`  in  ADDR_W  branch target address.
- `flagsPending`  in  1  an instruction that writes flags is in execute this cycle (flags register updates at next edge).
- `arithCarry`, `logicCarry`, `zero`, `sign`, `overflow`  in  1 each  current flags.
- `CarrySelectDelayed`  in  2  carry source for current flags.
- `stall`  out  1  hold issuing stage (combinational).
- `redirect`  out  1  one-cycle PC load pulse (registered).
- `pcTarget`  out  ADDR_W  target valid while `redirect`=1 (registered).
- `flush`  out  1  squash instruction in fetch/decode (registered).
- `takenCount`  out  CNT_W  saturating count of taken branches.

## Operation
- Effective carry C from `CarrySelectDelayed`: 0 → `arithCarry`, 1 → `logicCarry`, 2 → 0, 3 → 1. C=1 on subtract means no borrow.
- Condition codes: 0 always; 1 Z; 2 ~Z; 3 C; 4 ~C; 5 S; 6 ~S; 7 V; 8 ~V; 9 C&~Z (unsigned higher); 10 ~C|Z; 11 S==V (GE); 12 S!=V (LT); 13 ~Z&(S==V) (GT); 14 Z|(S!=V) (LE); 15 never.
- FSM states: IDLE, WAIT_FLAGS, FLUSH.
  - IDLE, `branchValid`=0: nothing.
  - IDLE, `branchValid`=1, `flagsPending`=0: evaluate now; taken → `redirect`=1/`pcTarget`=`targetIn` next cycle, go FLUSH with counter=FLUSH_DEPTH; not taken → stay IDLE, no pulse.
  - IDLE, `branchValid`=1, `flagsPending`=1: `stall`=1 this cycle, latch `condCode`/`targetIn`, go WAIT_FLAGS.
  - WAIT_FLAGS: `stall`=0; evaluate latched condition against now-updated flags; same taken/not-taken outcome as above; inputs `branchValid` ignored this cycle.
  - FLUSH: `flush`=1 each cycle, counter decrements; at 1 → IDLE. `branchValid` ignored (wrong-path).
- `takenCount` increments on each taken evaluation; saturates at all-ones.
- condCode 15 never redirects and never counts.

## Timing
- Reset (async, immediate): state IDLE, `stall`=0, `redirect`=0, `pcTarget`=0, `flush`=0, `takenCount`=0, latches cleared. Reset mid-WAIT or mid-FLUSH abandons the branch; no pulse after release.
- Latency: evaluation edge E → `redirect` high in cycle E+1 for exactly one cycle; `flush` high cycles E+1..E+FLUSH_DEPTH.
- Hazard path adds exactly one cycle (stall cycle, then evaluate).
- `stall` is combinational from `branchValid`, `flagsPending`, state; never asserted outside IDLE.
- Back-to-back not-taken branches: one evaluation per cycle, no bubbles.
- Branch arriving the cycle after FLUSH ends: accepted normally.

## Structure
- Shared package: condition-code constants (COND_ALWAYS … COND_NEVER), carry-select encodings, FSM state encoding.
- One sub-module `cond_eval`: purely combinational, takes flags + carry select + condCode, returns taken. FSM, latches, counters in `branch_resolver`.

## Test plan
- Z=1, condCode=1, targetIn=0x3C, no pending → `redirect`=1 one cycle later with `pcTarget`=0x3C, `flush`=1 for 2 cycles, `takenCount`=1.
- condCode=13, S=1,V=0,Z=0 → not taken: no `redirect`, no `flush`, count unchanged; same with S=V=1 → taken.
- CarrySelectDelayed=1, arithCarry=0, logicCarry=1, condCode=3 → taken; CarrySelectDelayed=2 → not taken.
- `branchValid`+`flagsPending`, flags change Z 0→1 at next edge, condCode=1 → `stall`=1 one cycle, then taken using new Z; `redirect` two cycles after branch arrival.
- Taken branch followed by `branchValid`=1 during both FLUSH cycles with condCode=0 → those ignored, single `redirect`, count=1.
- Assert `rst_n`=0 during FLUSH → `flush`/`redirect` drop immediately, IDLE after release; force `takenCount` to saturation → stays at 0xFFFF on further taken branches.
